// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: constants and types shared by the RGB LED PWM driver and its users.
package rgb_led_pkg;

    localparam int DEFAULT_DUTY_W = 8;
    localparam int NUM_CH         = 3;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2
    } ch_e;

    typedef struct packed {
        logic [DEFAULT_DUTY_W-1:0] red;
        logic [DEFAULT_DUTY_W-1:0] green;
        logic [DEFAULT_DUTY_W-1:0] blue;
    } rgb_duty_t;

    // Ticks per PWM period: the counter visits 0 .. 2^duty_w-2.
    function automatic int pwm_period_ticks(input int duty_w);
        return (1 << duty_w) - 1;
    endfunction

endpackage

// File: rtl/rgb_led_pwm_channel.sv
// rgb_led_pwm_channel: one colour's active duty register and its PWM compare.
// With RGB_LED_PWM_FADE_EN defined, the active duty walks one step per period toward a target.
module rgb_led_pwm_channel
    import rgb_led_pkg::*;
#(
    parameter int DUTY_W = DEFAULT_DUTY_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [DUTY_W-1:0] cnt_i,
    input  logic              wrap_i,
    input  logic              load_i,
    input  logic [DUTY_W-1:0] value_i,
    output logic              on_o
);

    logic [DUTY_W-1:0] active_q;
    logic [DUTY_W-1:0] active_d;

`ifdef RGB_LED_PWM_FADE_EN
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] target_d;

    // While disabled nothing is visible, so the active duty snaps to the target.
    always_comb begin
        target_d = load_i ? value_i : target_q;
        active_d = active_q;
        if (!enable_i) begin
            active_d = target_q;
        end else if (wrap_i) begin
            if (active_q < target_q) begin
                active_d = active_q + 1'b1;
            end else if (active_q > target_q) begin
                active_d = active_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target_q <= '0;
            active_q <= '0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
        end
    end
`else
    // load_i flags a pending value; it is taken only on a period boundary.
    always_comb begin
        active_d = active_q;
        if (load_i && (wrap_i || !enable_i)) begin
            active_d = value_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end
`endif

    assign on_o = enable_i && (cnt_i < active_q);

endmodule

// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: three-channel PWM driver for an active-low RGB LED with a valid/ready load port.
// Define RGB_LED_PWM_FADE_EN to make loads set a fade target instead of a boundary-applied value.
module rgb_led_pwm
    import rgb_led_pkg::*;
#(
    parameter int DUTY_W   = DEFAULT_DUTY_W,
    parameter int PRESCALE = 48
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DUTY_W-1:0] load_red,
    input  logic [DUTY_W-1:0] load_green,
    input  logic [DUTY_W-1:0] load_blue,
    output logic              period_start,
    output logic              led_red_n,
    output logic              led_green_n,
    output logic              led_blue_n
);

    localparam int                PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(pwm_period_ticks(DUTY_W) - 1);

    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] cnt_d;
    logic              period_start_q;
    logic [NUM_CH-1:0] led_n_q;
    logic [NUM_CH-1:0] ch_on;
    logic              tick;
    logic              wrap;
    logic              accept;
    logic [DUTY_W-1:0] load_val [NUM_CH];
    logic [DUTY_W-1:0] ch_value [NUM_CH];
    logic              ch_load;

    assign load_val[CH_RED]   = load_red;
    assign load_val[CH_GREEN] = load_green;
    assign load_val[CH_BLUE]  = load_blue;

    assign tick   = enable && (pcnt_q == PCNT_LAST);
    assign wrap   = tick && (cnt_q == CNT_LAST);
    assign accept = load_valid && load_ready;

    // Disabled: both counters park at 0 so the next enabled period is full length.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        if (!enable) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            pcnt_d = '0;
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q         <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            led_n_q        <= '1;
        end else begin
            pcnt_q         <= pcnt_d;
            cnt_q          <= cnt_d;
            period_start_q <= wrap;
            led_n_q        <= ~ch_on;
        end
    end

`ifdef RGB_LED_PWM_FADE_EN
    assign load_ready = 1'b1;
    assign ch_load    = accept;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fade_val
        assign ch_value[c] = load_val[c];
    end
`else
    logic              pending_q;
    logic [DUTY_W-1:0] shadow_q [NUM_CH];

    // Accept and transfer are exclusive: accept needs pending low, transfer needs it high.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= '0;
            end
        end else if (accept) begin
            pending_q <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= load_val[c];
            end
        end else if (pending_q && (wrap || !enable)) begin
            pending_q <= 1'b0;
        end
    end

    assign load_ready = ~pending_q;
    assign ch_load    = pending_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_shadow_val
        assign ch_value[c] = shadow_q[c];
    end
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_led_pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_channel (
            .clk_i    (clock),
            .rst_i    (reset),
            .enable_i (enable),
            .cnt_i    (cnt_q),
            .wrap_i   (wrap),
            .load_i   (ch_load),
            .value_i  (ch_value[c]),
            .on_o     (ch_on[c])
        );
    end

    assign period_start = period_start_q;
    assign led_red_n    = led_n_q[CH_RED];
    assign led_green_n  = led_n_q[CH_GREEN];
    assign led_blue_n   = led_n_q[CH_BLUE];

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb_rgb_led_pwm: directed bench for rgb_led_pwm at DUTY_W=8, PRESCALE=2 (510-cycle period).
// Define RGB_LED_PWM_FADE_EN for the fade build; the boundary-load checks then give way to fade checks.
module tb_rgb_led_pwm;
    import rgb_led_pkg::*;

    localparam int DUTY_W   = 8;
    localparam int PRESCALE = 2;
    localparam int PERIOD   = 510;
    localparam int PS_BOUND = 600;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              load_valid;
    logic              load_ready;
    logic [DUTY_W-1:0] load_red;
    logic [DUTY_W-1:0] load_green;
    logic [DUTY_W-1:0] load_blue;
    logic              period_start;
    logic              led_red_n;
    logic              led_green_n;
    logic              led_blue_n;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        rgb_duty_t duty;
        int        er;
        int        eg;
        int        eb;
    } vec_t;

    rgb_led_pwm #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_red     (load_red),
        .load_green   (load_green),
        .load_blue    (load_blue),
        .period_start (period_start),
        .led_red_n    (led_red_n),
        .led_green_n  (led_green_n),
        .led_blue_n   (led_blue_n)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int r, input int g, input int b,
                                input int er, input int eg, input int eb);
        vec_t v;
        v.duty.red   = 8'(r);
        v.duty.green = 8'(g);
        v.duty.blue  = 8'(b);
        v.er = er;
        v.eg = eg;
        v.eb = eb;
        return v;
    endfunction

    // Offer a triple for exactly one cycle once the port is ready.
    task automatic load_triple(input rgb_duty_t d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PS_BOUND && !ok; i++) begin
            if (load_ready) ok = 1'b1;
            else step();
        end
        load_valid = 1'b1;
        load_red   = d.red;
        load_green = d.green;
        load_blue  = d.blue;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_ps(output bit found);
        found = 1'b0;
        for (int i = 0; i < PS_BOUND && !found; i++) begin
            step();
            if (period_start) found = 1'b1;
        end
    endtask

    // Start on a period_start sample (or the cycle enable rises); count LED-on samples over one period.
    task automatic measure(output int lr, output int lg, output int lb, output int ps_at);
        lr = 0; lg = 0; lb = 0; ps_at = -1;
        for (int i = 1; i <= PERIOD; i++) begin
            step();
            if (!led_red_n)   lr++;
            if (!led_green_n) lg++;
            if (!led_blue_n)  lb++;
            if (period_start && ps_at < 0) ps_at = i;
        end
    endtask

    vec_t vecs [5];

    initial begin
        int lr, lg, lb, ps_at;
        bit found, ok, low_ok;

        vecs[0] = mk(128,   0, 255, 256,   0, 510);
        vecs[1] = mk(  1, 254,  10,   2, 508,  20);
        vecs[2] = mk(  0,   0,   0,   0,   0,   0);
        vecs[3] = mk(255, 128,  64, 510, 256, 128);
        vecs[4] = mk(200,  37,   3, 400,  74,   6);

        reset      = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b1;
        load_red   = 8'd77;
        load_green = 8'd77;
        load_blue  = 8'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_leds", int'({led_red_n, led_green_n, led_blue_n}), 7);
            check("reset_ready", int'(load_ready), 1);
            check("reset_period_start", int'(period_start), 0);
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        load_red   = '0;
        load_green = '0;
        load_blue  = '0;

        wait_ps(found);
        check("first_ps_found", int'(found), 1);
        measure(lr, lg, lb, ps_at);
        check("reset_no_xfer_red", lr, 0);
        check("reset_no_xfer_green", lg, 0);
        check("reset_no_xfer_blue", lb, 0);
        check("reset_period_len", ps_at, PERIOD);

`ifndef RGB_LED_PWM_FADE_EN
        for (int v = 0; v < 5; v++) begin
            load_triple(vecs[v].duty, ok);
            check("vec_ready_seen", int'(ok), 1);
            wait_ps(found);
            check("vec_ps_found", int'(found), 1);
            check("vec_ready_after_wrap", int'(load_ready), 1);
            measure(lr, lg, lb, ps_at);
            check("vec_red_on", lr, vecs[v].er);
            check("vec_green_on", lg, vecs[v].eg);
            check("vec_blue_on", lb, vecs[v].eb);
            check("vec_period_len", ps_at, PERIOD);
        end

        // Back-pressure: second triple held while the first is pending.
        load_valid = 1'b1;
        load_red   = 8'd10;
        load_green = '0;
        load_blue  = '0;
        step();
        load_red = 8'd200;
        low_ok = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < PS_BOUND && !found; i++) begin
            if (load_ready) low_ok = 1'b0;
            step();
            if (period_start) found = 1'b1;
        end
        check("bp_ready_low_while_pending", int'(low_ok), 1);
        check("bp_ps_found", int'(found), 1);
        check("bp_ready_after_wrap", int'(load_ready), 1);
        measure(lr, lg, lb, ps_at);
        check("bp_first_duty", lr, 20);
        check("bp_period_len", ps_at, PERIOD);
        measure(lr, lg, lb, ps_at);
        load_valid = 1'b0;
        check("bp_second_duty", lr, 400);

        // Load landing on the wrap cycle waits a full extra period.
        for (int i = 0; i < PERIOD - 1; i++) step();
        load_valid = 1'b1;
        load_red   = 8'd50;
        step();
        load_valid = 1'b0;
        check("coinc_ps_on_time", int'(period_start), 1);
        check("coinc_accepted_pending", int'(load_ready), 0);
        measure(lr, lg, lb, ps_at);
        check("coinc_old_duty_kept", lr, 400);
        measure(lr, lg, lb, ps_at);
        check("coinc_new_duty", lr, 100);

        // Enable dropped mid-period with a load pending.
        load_valid = 1'b1;
        load_red   = 8'd90;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("en_pending_before_drop", int'(load_ready), 0);
        enable = 1'b0;
        step();
        check("en_off_leds", int'({led_red_n, led_green_n, led_blue_n}), 7);
        check("en_off_ps", int'(period_start), 0);
        step();
        check("en_off_transfer", int'(load_ready), 1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (period_start || !led_red_n) found = 1'b1;
        end
        check("en_off_quiet", int'(found), 0);
        enable = 1'b1;
        measure(lr, lg, lb, ps_at);
        check("en_restart_period_len", ps_at, PERIOD);
        check("en_restart_duty", lr, 180);

        // Reset mid-period with red lit and a load pending.
        load_valid = 1'b1;
        load_red   = 8'd33;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 137; i++) step();
        check("rst_mid_red_lit", int'(led_red_n), 0);
        reset = 1'b1;
        step();
        check("rst_mid_leds", int'({led_red_n, led_green_n, led_blue_n}), 7);
        check("rst_mid_ready", int'(load_ready), 1);
        check("rst_mid_ps", int'(period_start), 0);
        reset = 1'b0;
        wait_ps(found);
        check("rst_mid_ps_found", int'(found), 1);
        measure(lr, lg, lb, ps_at);
        check("rst_mid_active_cleared", lr, 0);
`else
        // Fade: red target 5 from 0, one step per wrap.
        load_valid = 1'b1;
        load_red   = 8'd5;
        step();
        load_valid = 1'b0;
        check("fade_ready_after_load", int'(load_ready), 1);
        measure(lr, lg, lb, ps_at);
        check("fade_period0", lr, 0);
        for (int p = 1; p <= 6; p++) begin
            check("fade_ready", int'(load_ready), 1);
            measure(lr, lg, lb, ps_at);
            check("fade_on_time", lr, (2 * p < 10) ? 2 * p : 10);
            check("fade_period_len", ps_at, PERIOD);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rgb_led_pwm.md
# rgb_led_pwm

Three-channel PWM driver for the board's active-low RGB LED (led_red_n, led_green_n, led_blue_n). It takes per-channel brightness values over a valid/ready load interface and drives the LED pins directly. Each new value is applied only at a PWM period boundary, so updates never glitch. It is the output-side counterpart of the button-input conditioning: user logic writes brightness in, and this block drives the physical pins.

## Interface
Parameters:
- DUTY_W, 8: duty width in bits. PWM period is 2^DUTY_W−1 ticks.
- PRESCALE, 48: clock cycles per PWM tick (≥1).

Ports:
- clock  in  1  single clock domain
- reset  in  1  synchronous, active-high
- enable  in  1  1 = PWM running; 0 = all LEDs off
- load_valid  in  1  brightness triple offered
- load_ready  out  1  block can accept a triple
- load_red, load_green, load_blue  in  DUTY_W each  requested duty
- period_start  out  1  one-cycle pulse on the cycle the PWM counter wraps to 0
- led_red_n, led_green_n, led_blue_n  out  1 each  active-low LED drives, registered

## Operation
- Prescaler pcnt counts 0..PRESCALE−1. A tick occurs when pcnt == PRESCALE−1.
- PWM counter cnt advances by one per tick over 0..2^DUTY_W−2, then wraps to 0.
- Wrap = tick with cnt == 2^DUTY_W−2. period_start is high on the cycle after a wrap, aligned with cnt == 0.
- Channel on when cnt < active_duty. Duty 0 = always off. Duty 2^DUTY_W−1 = always on.
- led_x_n = ~(enable & on_x), registered.
- Load handshake: a transfer occurs when load_valid & load_ready. The triple goes into shadow registers and pending is set. load_ready = ~pending.
- At a wrap with pending set: active ← shadow and pending clears, so load_ready rises the next cycle.
- A load accepted in the same cycle as a wrap is not applied by that wrap. It applies at the following wrap.
- enable low: pcnt and cnt are held at 0 and period_start stays low. Every cycle acts as a boundary, so a pending shadow transfers on the next cycle. Outputs are 1.
- After enable rises, cnt starts at 0. The first period is full length.
- Reset values: pcnt=0, cnt=0, active=0, shadow=0, pending=0, load_ready=1, period_start=0, all led_*_n=1.
- Reset asserted mid-period returns every register to its reset value on the next edge.

## Timing
- Brightness latency: from load acceptance to the first affected output is at most one full period plus 2 cycles, with enable high.
- Output latency: cnt/active state reaches the pins one cycle later through the output register.
- Handshake: load_valid may be held high. No combinational path from load_valid to load_ready.
- Period length is exactly PRESCALE·(2^DUTY_W−1) clock cycles.

## Configuration
RGB_LED_PWM_FADE_EN:
- Defined:
  - An accepted load writes a target register directly. pending is not used and load_ready is constantly 1 after reset.
  - At each wrap, each channel's active value steps ±1 toward its target. It holds when equal.
  - A full 0→255 fade takes 255 periods.
  - With enable low, active jumps to target immediately.
- Undefined: the behaviour is as described under Operation, with an immediate step to the new value at the wrap.

## Structure
- Package rgb_led_pkg:
  - DUTY_W default constant
  - channel index enum (CH_RED, CH_GREEN, CH_BLUE)
  - packed struct rgb_duty_t with three DUTY_W fields
- Sub-module rgb_led_pwm_channel, instantiated 3×:
  - holds the active duty (plus the target and fade stepper under RGB_LED_PWM_FADE_EN)
  - performs the cnt < active compare
  - inputs: cnt, wrap strobe, load strobe, value
- Top level holds the prescaler, cnt, shadow/pending handshake, output registers and period_start.

## Test plan
Use DUTY_W=8 and PRESCALE=2 (510-cycle period) throughout.
- **Reset:** assert reset for 3 cycles with valid high. Required: led_*_n=1, load_ready=1, no period_start, no transfer accepted.
- **Mixed duties:** load R=128, G=0, B=255, then wait two periods. Required:
  - led_red_n low for exactly 256 cycles of each 510-cycle period
  - led_green_n always 1
  - led_blue_n always 0
  - period_start pulses every 510 cycles
- **Back-pressure:** load R=10, then hold valid with R=200. Required: load_ready stays low until the cycle after the wrap; the second triple is accepted then and appears one period later.
- **Load coincident with wrap:** load lands on the wrap cycle. Required: old duty persists a full extra period.
- **Enable and reset mid-period:** drop enable mid-period with a load pending. Required: outputs go to 1 next cycle, and active updates within 2 cycles. Re-enable: cnt restarts at 0. Reset mid-period: all outputs return to reset values next edge.
- **Fade (RGB_LED_PWM_FADE_EN):** load R=0→5 with R initially 0. Required: the R on-time grows by 2 cycles per period over 5 periods, then holds at 10 cycles; load_ready remains 1.
